// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    SIZE_BYTE,
    SIZE_DWORD
  } size_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_size;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised backing store: asynchronous read, synchronous byte-enabled write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        byteEn,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mergedWord;

  assign rdata = mem[addr];

  // Read-modify-write merge keeps a single write driver for the whole word.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign mergedWord[gi*8 +: 8] = byteEn[gi] ? wdata[gi*8 +: 8] : rdata[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (|byteEn) begin
      mem[addr] <= mergedWord;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder for the MEM stage; one transaction in flight.
// Optional access fault checking is enabled by defining DMEM_ACCESS_CHECK_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_e            stateReg, stateNext;
  logic [CW-1:0]     cntReg, cntNext;
  logic [DATA_W-1:0] rdataReg;
  logic              errReg;

  logic [AW-1:0]     wordIdx;
  logic [2:0]        lane;
  logic              isDword;
  logic              accept;
  logic              fault;
  logic [7:0]        laneByte;
  logic [7:0]        byteEn;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] arrRdata;
  logic [DATA_W-1:0] loadData;

  assign wordIdx = bus.req_addr[AW+2:3];
  assign lane    = bus.req_addr[2:0];
  assign isDword = (bus.req_size == SIZE_DWORD);
  assign accept  = (stateReg == IDLE) && bus.req_valid;

`ifdef DMEM_ACCESS_CHECK_EN
  assign fault = (isDword && (lane != 3'd0)) || (bus.req_addr >= 64'(DEPTH * 8));
`else
  assign fault = 1'b0;
`endif

  assign laneByte = arrRdata[{lane, 3'b000} +: 8];
  assign loadData = fault   ? '0 :
                    isDword ? arrRdata : {56'b0, laneByte};
  assign wrData   = isDword ? bus.req_wdata : {8{bus.req_wdata[7:0]}};
  // Stores commit at the acceptance edge so a following load sees them.
  assign byteEn   = (accept && bus.req_write && !fault) ?
                    (isDword ? 8'hFF : (8'd1 << lane)) : 8'h00;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk    (clk),
    .addr   (wordIdx),
    .wdata  (wrData),
    .byteEn (byteEn),
    .rdata  (arrRdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      rdataReg <= '0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (accept) begin
        rdataReg <= bus.req_write ? '0 : loadData;
        errReg   <= fault;
      end
    end
  end

  always_comb begin
    stateNext     = stateReg;
    cntNext       = cntReg;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (stateReg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            stateNext = RESP;
          end else begin
            stateNext = BUSY;
            cntNext   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cntReg == '0) stateNext = RESP;
        else              cntNext   = cntReg - 1'b1;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.rsp_rdata = rdataReg;
  assign bus.rsp_err   = errReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=3 instance and a LATENCY=1 instance.
`timescale 1ns/1ps
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if bus3();
  data_mem_responder_if bus1();

  data_mem_responder #(.DEPTH(64), .LATENCY(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  virtual data_mem_responder_if vif;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        expQ[$];
  logic [63:0] model [64];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic doReq(input string tag, input logic w, input logic sz,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] expData, input logic expErr,
                       input int expLat, input int stallCycles);
    exp_t e;
    int   lat;
    int   waitCnt;
    e.data = expData;
    e.err  = expErr;
    expQ.push_back(e);

    @(negedge clk);
    vif.req_write = w;
    vif.req_size  = sz;
    vif.req_addr  = addr;
    vif.req_wdata = wdata;
    vif.req_valid = 1'b1;
    waitCnt = 0;
    while (!vif.req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkVal({tag, "_accept"}, 64'(vif.req_ready), 64'd1);
    @(posedge clk);
    #1;
    // Scramble request fields: they must only be sampled at acceptance.
    vif.req_valid = 1'b0;
    vif.req_addr  = 64'($urandom);
    vif.req_wdata = {$urandom, $urandom};
    vif.req_write = ~w;
    vif.req_size  = ~sz;

    lat = 1;
    while (!vif.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal({tag, "_lat"}, 64'(lat), 64'(expLat));

    if (expQ.size() == 0) begin
      checkVal({tag, "_queue"}, 64'd0, 64'd1);
      return;
    end
    e = expQ.pop_front();

    if (stallCycles > 0) begin
      // Stray store held during RESP must never be taken.
      vif.req_valid = 1'b1;
      vif.req_write = 1'b1;
      vif.req_size  = 1'b1;
      vif.req_addr  = 64'h20;
      vif.req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 0; i < stallCycles; i++) begin
        @(posedge clk);
        #1;
        checkVal({tag, "_stall_valid"}, 64'(vif.rsp_valid), 64'd1);
        checkVal({tag, "_stall_data"}, vif.rsp_rdata, e.data);
        checkVal({tag, "_stall_rdy"}, 64'(vif.req_ready), 64'd0);
      end
    end

    checkVal({tag, "_data"}, vif.rsp_rdata, e.data);
    checkVal({tag, "_err"}, 64'(vif.rsp_err), 64'(e.err));
    $display("txn %s write=%0b size=%0b addr=%h rdata=%h err=%0b lat=%0d",
             tag, w, sz, addr, vif.rsp_rdata, vif.rsp_err, lat);

    vif.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    vif.rsp_ready = 1'b0;
    checkVal({tag, "_done_valid"}, 64'(vif.rsp_valid), 64'd0);
    checkVal({tag, "_done_rdy"}, 64'(vif.req_ready), 64'd1);
    vif.req_valid = 1'b0;
  endtask

  task automatic initBus(input int which);
    if (which == 3) vif = bus3;
    else            vif = bus1;
    vif.req_valid = 1'b0;
    vif.req_write = 1'b0;
    vif.req_size  = 1'b0;
    vif.req_addr  = '0;
    vif.req_wdata = '0;
    vif.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    logic [5:0]  wIdx;
    logic [2:0]  ln;
    logic        w;
    logic        sz;
    logic [63:0] addr;
    logic [63:0] expd;

    reset = 1'b0;
    initBus(1);
    initBus(3);
    #12;
    checkVal("rst_req_ready", 64'(vif.req_ready), 64'd1);
    checkVal("rst_rsp_valid", 64'(vif.rsp_valid), 64'd0);
    checkVal("rst_rsp_rdata", vif.rsp_rdata, 64'd0);
    checkVal("rst_rsp_err", 64'(vif.rsp_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    doReq("st_dw10", 1'b1, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 3, 0);
    doReq("ld_dw10", 1'b0, 1'b1, 64'h10, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 0);
    doReq("st_b13", 1'b1, 1'b0, 64'h13, 64'hDEAD_BEEF_CAFE_12FF, 64'd0, 1'b0, 3, 0);
    doReq("ld_dw10b", 1'b0, 1'b1, 64'h10, 64'd0, 64'h0123_4567_FFAB_CDEF, 1'b0, 3, 0);
    doReq("ld_b13", 1'b0, 1'b0, 64'h13, 64'd0, 64'h0000_0000_0000_00FF, 1'b0, 3, 0);
    doReq("st_dw20", 1'b1, 1'b1, 64'h20, 64'h1111_2222_3333_4444, 64'd0, 1'b0, 3, 0);
    doReq("ld_stall", 1'b0, 1'b1, 64'h10, 64'd0, 64'h0123_4567_FFAB_CDEF, 1'b0, 3, 5);
    doReq("ld_dw20", 1'b0, 1'b1, 64'h20, 64'd0, 64'h1111_2222_3333_4444, 1'b0, 3, 0);
    doReq("st_dw00", 1'b1, 1'b1, 64'h0, 64'h5555_6666_7777_8888, 64'd0, 1'b0, 3, 0);

`ifdef DMEM_ACCESS_CHECK_EN
    doReq("st_mis14", 1'b1, 1'b1, 64'h14, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0, 1'b1, 3, 0);
    doReq("ld_after_mis", 1'b0, 1'b1, 64'h10, 64'd0, 64'h0123_4567_FFAB_CDEF, 1'b0, 3, 0);
    doReq("ld_oob200", 1'b0, 1'b1, 64'h200, 64'd0, 64'd0, 1'b1, 3, 0);
`else
    doReq("st_mis14", 1'b1, 1'b1, 64'h14, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0, 1'b0, 3, 0);
    doReq("ld_after_mis", 1'b0, 1'b1, 64'h10, 64'd0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 3, 0);
    doReq("ld_alias200", 1'b0, 1'b1, 64'h200, 64'd0, 64'h5555_6666_7777_8888, 1'b0, 3, 0);
`endif

    // Reset during BUSY of a load.
    @(negedge clk);
    vif.req_write = 1'b0;
    vif.req_size  = 1'b1;
    vif.req_addr  = 64'h10;
    vif.req_valid = 1'b1;
    @(posedge clk);
    #1;
    vif.req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkVal("rst_mid_busy", 64'(vif.req_ready), 64'd0);
    reset = 1'b0;
    #1;
    checkVal("rst_mid_valid", 64'(vif.rsp_valid), 64'd0);
    checkVal("rst_mid_rdy", 64'(vif.req_ready), 64'd1);
    checkVal("rst_mid_rdata", vif.rsp_rdata, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkVal("rst_after_valid", 64'(vif.rsp_valid), 64'd0);
    $display("txn rst_mid reset during busy, rsp_valid=%0b req_ready=%0b", vif.rsp_valid, vif.req_ready);
    doReq("ld_post_rst", 1'b0, 1'b1, 64'h20, 64'd0, 64'h1111_2222_3333_4444, 1'b0, 3, 0);

    // Randomised traffic on words 8..15 against a reference model.
    for (int i = 8; i < 16; i++) begin
      d = {$urandom, $urandom};
      model[i] = d;
      doReq("rnd_init", 1'b1, 1'b1, 64'(i * 8), d, 64'd0, 1'b0, 3, 0);
    end
    for (int i = 0; i < 12; i++) begin
      wIdx = 6'($urandom_range(8, 15));
      w    = 1'($urandom_range(0, 1));
      sz   = 1'($urandom_range(0, 1));
      ln   = sz ? 3'd0 : 3'($urandom_range(0, 7));
      d    = {$urandom, $urandom};
      addr = {55'd0, wIdx, ln};
      if (w) begin
        expd = 64'd0;
        if (sz) model[wIdx] = d;
        else    model[wIdx][{ln, 3'b000} +: 8] = d[7:0];
      end else begin
        expd = sz ? model[wIdx] : {56'd0, model[wIdx][{ln, 3'b000} +: 8]};
      end
      doReq("rnd", w, sz, addr, d, expd, 1'b0, 3, 0);
    end

    initBus(1);
    doReq("l1_st_dw10", 1'b1, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 1, 0);
    doReq("l1_ld_dw10", 1'b0, 1'b1, 64'h10, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 1, 0);
    doReq("l1_ld_stall", 1'b0, 1'b0, 64'h11, 64'd0, 64'h0000_0000_0000_00CD, 1'b0, 1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
